bsg_mesh_proc_endpoint: RTL

Processor-side endpoint attached to the P port of one `bsg_mesh_router` in the 2D mesh. On transmit, it turns (destination, payload) requests into mesh packets stamped with this tile's source coordinates and buffers them into the router. On receive, it buffers packets the router ejects on P, checks that each was delivered to the correct tile, and presents payload and source to the local consumer. It also keeps traffic counters and a sticky misroute flag for formal and simulation checks of the mesh.

---
 rtl/bsg_mesh_proc_endpoint.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/bsg_mesh_proc_endpoint.sv
// Mesh P-port endpoint: stamps TX requests into packets and buffers them toward the router,
// and buffers RX packets that pass the destination check. Each direction adds one cycle with no bypass, and ready is simply ~full.
module bsg_mesh_proc_endpoint_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  localparam int ptr_w_lp = $clog2(els_p);

  logic [width_p-1:0]  mem_q [els_p];
  logic [width_p-1:0]  mem_d [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic                full_q, full_d, empty_q, empty_d;
  logic                enq, deq;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign ready_o = ~full_q;
  assign v_o     = ~empty_q;
  assign data_o  = empty_q ? '0 : mem_q[rptr_q];
  assign enq     = v_i & ~full_q;
  assign deq     = yumi_i;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    full_d  = full_q;
    empty_d = empty_q;
    if (enq) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (deq) rptr_d = ptr_inc(rptr_q);
    // Simultaneous enqueue and dequeue leaves occupancy, and so full/empty, unchanged.
    if (enq && !deq) begin
      full_d  = (ptr_inc(wptr_q) == rptr_q);
      empty_d = 1'b0;
    end else if (deq && !enq) begin
      empty_d = (ptr_inc(rptr_q) == wptr_q);
      full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> !empty_q);
endmodule

module bsg_mesh_proc_endpoint #(
  parameter int data_width_p   = 4,
  parameter int x_cord_width_p = 2,
  parameter int y_cord_width_p = 2,
  parameter int els_p          = 2,
  parameter int count_width_p  = 16,
  localparam int width_lp = 2*x_cord_width_p + 2*y_cord_width_p + data_width_p
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic                      tx_v_i,
  input  logic [x_cord_width_p-1:0] tx_dest_x_i,
  input  logic [y_cord_width_p-1:0] tx_dest_y_i,
  input  logic [data_width_p-1:0]   tx_data_i,
  output logic                      tx_ready_and_o,
  output logic                      link_v_o,
  output logic [width_lp-1:0]       link_data_o,
  input  logic                      link_yumi_i,
  input  logic                      link_v_i,
  input  logic [width_lp-1:0]       link_data_i,
  output logic                      link_ready_and_o,
  output logic                      rx_v_o,
  output logic [data_width_p-1:0]   rx_data_o,
  output logic [x_cord_width_p-1:0] rx_src_x_o,
  output logic [y_cord_width_p-1:0] rx_src_y_o,
  input  logic                      rx_yumi_i,
  output logic [count_width_p-1:0]  tx_count_o,
  output logic [count_width_p-1:0]  rx_count_o,
  output logic                      err_misroute_o
);
  typedef struct packed {
    logic [y_cord_width_p-1:0] src_y;
    logic [x_cord_width_p-1:0] src_x;
    logic [data_width_p-1:0]   data;
    logic [y_cord_width_p-1:0] dest_y;
    logic [x_cord_width_p-1:0] dest_x;
  } pkt_t;

  localparam int rx_w_lp = y_cord_width_p + x_cord_width_p + data_width_p;

  pkt_t                     tx_pkt, rx_pkt;
  logic                     tx_fifo_rdy, rx_fifo_rdy, rx_accept, rx_good;
  logic [rx_w_lp-1:0]       rx_head;
  logic [count_width_p-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic                     err_q, err_d;

  always_comb begin
    tx_pkt.src_y  = my_y_i;
    tx_pkt.src_x  = my_x_i;
    tx_pkt.data   = tx_data_i;
    tx_pkt.dest_y = tx_dest_y_i;
    tx_pkt.dest_x = tx_dest_x_i;
  end

  // Readies are forced low while reset is held so nothing handshakes into a flushing buffer.
  assign tx_ready_and_o   = tx_fifo_rdy & ~reset_i;
  assign link_ready_and_o = rx_fifo_rdy & ~reset_i;

  bsg_mesh_proc_endpoint_fifo #(.width_p(width_lp), .els_p(els_p)) tx_fifo (
    .clk_i(clk_i), .reset_i(reset_i),
    .v_i(tx_v_i), .data_i(tx_pkt), .ready_o(tx_fifo_rdy),
    .v_o(link_v_o), .data_o(link_data_o), .yumi_i(link_yumi_i)
  );

  assign rx_pkt    = link_data_i;
  assign rx_accept = link_v_i & link_ready_and_o;
  assign rx_good   = (rx_pkt.dest_x == my_x_i) && (rx_pkt.dest_y == my_y_i);

  bsg_mesh_proc_endpoint_fifo #(.width_p(rx_w_lp), .els_p(els_p)) rx_fifo (
    .clk_i(clk_i), .reset_i(reset_i),
    .v_i(rx_accept & rx_good), .data_i({rx_pkt.src_y, rx_pkt.src_x, rx_pkt.data}),
    .ready_o(rx_fifo_rdy), .v_o(rx_v_o), .data_o(rx_head), .yumi_i(rx_yumi_i)
  );

  assign {rx_src_y_o, rx_src_x_o, rx_data_o} = rx_head;

  always_comb begin
    tx_count_d = tx_count_q + count_width_p'(link_yumi_i);
    rx_count_d = rx_count_q + count_width_p'(rx_accept & rx_good);
    err_d      = err_q | (rx_accept & ~rx_good);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_count_q <= '0;
      rx_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
      err_q      <= err_d;
    end
  end

  assign tx_count_o     = tx_count_q;
  assign rx_count_o     = rx_count_q;
  assign err_misroute_o = err_q;
endmodule
